// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back source encodings, the hardwired
// zero register index and the default datapath/index widths.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select (ALU result, load data, link address).
// Ports: sel_i, alu_i, mem_i, link_i -> y_o. Shared with forwarding.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] link_i,
  output logic [DATA_W-1:0] y_o
);

  // Encoding 11 is reserved and falls back to the ALU result.
  always_comb begin
    y_o = alu_i;
    case (sel_i)
      WB_MEM:  y_o = mem_i;
      WB_LINK: y_o = link_i;
      default: y_o = alu_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with write-through bypass.
// Ports: MEM/WB inputs, rd1/rd2 (ID), dbg (display), wb_data/wb_we out.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] aluout_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic [DATA_W-1:0] pc_next_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic [ADDR_W-1:0] dbg_ra_i,
  output logic [DATA_W-1:0] dbg_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_we_o
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel_i  (MemtoReg),
    .alu_i  (aluout_i),
    .mem_i  (dout_i),
    .link_i (pc_next_i),
    .y_o    (wb_data_o)
  );

  assign wb_we_o = RegWrite & (wa_i != ZERO);

  // Register 0 is never written because wb_we_o excludes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we_o) begin
      regs_q[wa_i] <= wb_data_o;
    end
  end

  // Write-through bypass lets ID see the value committed this cycle.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == ZERO) begin
      v = '0;
    end else if (wb_we_o && (a == wa_i)) begin
      v = wb_data_o;
    end else begin
      v = regs_q[a];
    end
    return v;
  endfunction

  assign rd1_o    = rd(ra1_i);
  assign rd2_o    = rd(ra2_i);
  assign dbg_rd_o = rd(dbg_ra_i);

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected port values,
// a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic [31:0] aluout_i, dout_i, pc_next_i;
  logic [4:0]  wa_i, ra1_i, ra2_i, dbg_ra_i;
  logic [31:0] rd1_o, rd2_o, dbg_rd_o, wb_data_o;
  logic        wb_we_o;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .aluout_i  (aluout_i),
    .dout_i    (dout_i),
    .pc_next_i (pc_next_i),
    .wa_i      (wa_i),
    .ra1_i     (ra1_i),
    .ra2_i     (ra2_i),
    .rd1_o     (rd1_o),
    .rd2_o     (rd2_o),
    .dbg_ra_i  (dbg_ra_i),
    .dbg_rd_o  (dbg_rd_o),
    .wb_data_o (wb_data_o),
    .wb_we_o   (wb_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   passed = 0;

  localparam int P_RD1 = 0, P_RD2 = 1, P_DBG = 2, P_WBD = 3, P_WE = 4;

  always @(negedge clk) begin
    if (RegWrite === 1'b1 && $isunknown(MemtoReg)) begin
      total++;
      $display("FAIL memtoreg_x: MemtoReg=%b with RegWrite=1, required known",
               MemtoReg);
    end
    while (q.size() > 0) begin
      chk_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        P_RD1:   act = rd1_o;
        P_RD2:   act = rd2_o;
        P_DBG:   act = dbg_rd_o;
        P_WBD:   act = wb_data_o;
        default: act = {31'd0, wb_we_o};
      endcase
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
    end
  end

  task automatic expect_v(input string n, input int s, input logic [31:0] v);
    chk_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input logic rw, input logic [1:0] m,
                     input logic [4:0] wa, input logic [31:0] alu,
                     input logic [31:0] dout, input logic [31:0] pc,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd);
    @(posedge clk);
    #1;
    RegWrite  = rw;
    MemtoReg  = m;
    wa_i      = wa;
    aluout_i  = alu;
    dout_i    = dout;
    pc_next_i = pc;
    ra1_i     = r1;
    ra2_i     = r2;
    dbg_ra_i  = rd;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd);
    cyc(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, r1, r2, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    RegWrite = 1'b0; MemtoReg = 2'b00; wa_i = '0;
    aluout_i = '0; dout_i = '0; pc_next_i = '0;
    ra1_i = '0; ra2_i = '0; dbg_ra_i = '0;

    idle(5'd1, 5'd17, 5'd31);
    expect_v("reset_rd1", P_RD1, 32'h0);
    expect_v("reset_rd2", P_RD2, 32'h0);
    expect_v("reset_dbg", P_DBG, 32'h0);
    expect_v("reset_we",  P_WE,  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Source select onto reg5
    for (int m = 0; m < 4; m++) begin
      logic [31:0] ev;
      case (m)
        1:       ev = 32'h22;
        2:       ev = 32'h33;
        default: ev = 32'h11;
      endcase
      cyc(1'b1, 2'(m), 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 5'd5);
      expect_v($sformatf("sel%0d_wbdata", m), P_WBD, ev);
      expect_v($sformatf("sel%0d_we", m),     P_WE,  32'h1);
      expect_v($sformatf("sel%0d_rd1", m),    P_RD1, ev);
    end
    idle(5'd5, 5'd5, 5'd5);
    expect_v("sel_stored_rd1", P_RD1, 32'h11);
    expect_v("sel_stored_dbg", P_DBG, 32'h11);

    // Zero register
    cyc(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_v("zero_we",     P_WE,  32'h0);
    expect_v("zero_wbdata", P_WBD, 32'hFFFF_FFFF);
    expect_v("zero_rd1",    P_RD1, 32'h0);
    idle(5'd0, 5'd0, 5'd0);
    expect_v("zero_rd1_next", P_RD1, 32'h0);

    // Bypass
    cyc(1'b1, 2'b00, 5'd7, 32'hA, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    cyc(1'b1, 2'b00, 5'd7, 32'hB, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    expect_v("byp_rd1", P_RD1, 32'hB);
    expect_v("byp_rd2", P_RD2, 32'hB);
    expect_v("byp_dbg", P_DBG, 32'hB);
    idle(5'd7, 5'd7, 5'd7);
    expect_v("byp_rd1_after", P_RD1, 32'hB);
    expect_v("byp_rd2_after", P_RD2, 32'hB);
    expect_v("byp_dbg_after", P_DBG, 32'hB);

    // Sweep regs 1..31 via MEM source, checking bypass on dbg
    for (int i = 1; i < 32; i++) begin
      cyc(1'b1, 2'b01, 5'(i), 32'hDEAD, 32'h100 + i, 32'h0,
          5'd0, 5'd0, 5'(i));
      expect_v($sformatf("sweep_wr%0d", i), P_DBG, 32'h100 + i);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      e1 = (i == 0) ? 32'h0 : 32'h100 + i;
      e2 = (i == 31) ? 32'h0 : 32'h100 + (31 - i);
      idle(5'(i), 5'(31 - i), 5'(i));
      expect_v($sformatf("sweep_rd1_%0d", i), P_RD1, e1);
      expect_v($sformatf("sweep_rd2_%0d", i), P_RD2, e2);
      expect_v($sformatf("sweep_dbg_%0d", i), P_DBG, e1);
    end

    // Write disable
    cyc(1'b0, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
    expect_v("wdis_we",  P_WE,  32'h0);
    expect_v("wdis_rd1", P_RD1, 32'h109);
    idle(5'd9, 5'd9, 5'd9);
    expect_v("wdis_rd1_next", P_RD1, 32'h109);

    // Reset mid-cycle with an in-flight write to reg3
    cyc(1'b1, 2'b00, 5'd3, 32'h77, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    rst = 1'b1;
    expect_v("rstmid_rd1", P_RD1, 32'h0);
    expect_v("rstmid_rd2", P_RD2, 32'h0);
    expect_v("rstmid_dbg_byp", P_DBG, 32'h77);
    idle(5'd3, 5'd31, 5'd9);
    expect_v("rstmid_rd1_r3", P_RD1, 32'h0);
    expect_v("rstmid_rd2_r31", P_RD2, 32'h0);
    expect_v("rstmid_dbg_r9", P_DBG, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd3, 5'd7, 5'd5);
    expect_v("postrst_rd1", P_RD1, 32'h0);
    expect_v("postrst_rd2", P_RD2, 32'h0);
    expect_v("postrst_dbg", P_DBG, 32'h0);

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d checks pending, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage plus architectural register file for the 5-stage pipelined CPU. Consumes the MEM/WB pipeline outputs, selects the write-back value (ALU result, load data, or link address), and commits it to a 32 x 32-bit register file. Serves the two ID-stage read ports with same-cycle write-through bypass, and a third read port for the debug/VGA display path.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- MemtoReg  in  2  write-back source select from MEM/WB
- RegWrite  in  1  write enable from MEM/WB
- aluout_i  in  DATA_W  ALU result from MEM/WB
- dout_i  in  DATA_W  load data from MEM/WB
- pc_next_i  in  DATA_W  link address (PC+4) from MEM/WB
- wa_i  in  ADDR_W  destination register index from MEM/WB
- ra1_i, ra2_i  in  ADDR_W  ID-stage read indices (rs, rt)
- rd1_o, rd2_o  out  DATA_W  ID-stage read data
- dbg_ra_i  in  ADDR_W  debug read index
- dbg_rd_o  out  DATA_W  debug read data
- wb_data_o  out  DATA_W  selected write-back value (to forwarding unit)
- wb_we_o  out  1  effective write enable (RegWrite and wa_i != 0)

## Operation
- Write-back select, combinational: MemtoReg 00 -> aluout_i; 01 -> dout_i; 10 -> pc_next_i; 11 -> aluout_i (reserved, defined).
- wb_we_o = RegWrite & (wa_i != 0). Register 0 is hardwired zero: never written, always reads 0.
- Commit: on rising clk with wb_we_o = 1, regs[wa_i] <= wb_data_o. No other register changes.
- Read ports (rd1, rd2, dbg), combinational: index 0 -> 0; index == wa_i with wb_we_o = 1 -> wb_data_o (write-through bypass, removes the WB/ID structural hazard); else regs[index].
- Simultaneous events: all three ports may read the same index being written; all return the bypassed value. rd1 and rd2 on the same index return identical data.
- No read-side enables; reads are unconditional.

## Timing
- Reset: asynchronous assertion clears all 32 registers to 0 immediately; rd1_o/rd2_o/dbg_rd_o read 0 for any index while rst = 1 and no write is bypassed. Bypass remains active during reset (wb_data_o is combinational), but no commit occurs while rst = 1.
- Deassertion: first commit possible at the first rising clk with rst = 0.
- Write latency: value is visible on read ports combinationally in the write cycle (bypass), and from storage from the following cycle onward.
- Read latency: 0 cycles (combinational).
- Reset mid-operation: an in-flight write in the cycle rst asserts is dropped.
- Unknown MemtoReg (X) is a verification error; the bench flags it whenever RegWrite = 1.

## Structure
- Shared package cpu_pkg: MemtoReg encodings WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10; REG_ZERO = 5'd0; DATA_W/ADDR_W defaults.
- Sub-module wb_mux: the 3-way write-back select, also reused by the forwarding unit. Storage, bypass and the three read ports stay in wb_regfile.

## Test plan
- Reset: preload regs via writes, assert rst mid-cycle -> all indices read 0 immediately; a write requested in that cycle is not committed.
- Source select: RegWrite = 1, wa_i = 5, aluout_i = 0x11, dout_i = 0x22, pc_next_i = 0x33, MemtoReg 00/01/10/11 over four cycles -> reg5 reads 0x11, 0x22, 0x33, 0x11.
- Zero register: RegWrite = 1, wa_i = 0, aluout_i = 0xFFFFFFFF -> wb_we_o = 0, rd1 at index 0 reads 0 same and next cycle.
- Bypass: reg7 = 0xA; write 0xB to reg7 with ra1 = ra2 = dbg = 7 -> all three read 0xB in the write cycle, 0xB afterwards.
- Write disable: RegWrite = 0, wa_i = 9, aluout_i = 0x55 -> reg9 unchanged, no bypass, wb_we_o = 0.
- Sweep: write index+0x100 to regs 1..31 back-to-back, read all via both ports and debug -> exact values, reg0 = 0.
